// File: rtl/scoreboard.sv
// rtl/scoreboard.sv - cycle-accurate reference model of the 4-bit multi-mode counter
// Optional feature macro: SB_DOWN3_EN enables the count-down-by-3 mode (MODO=10);
// without it MODO=10 holds the count, matching a counter built without that mode.

module scoreboard (
  input  logic       clk,
  input  logic       RESET,
  input  logic       ENABLE,
  input  logic [3:0] sb_D,
  input  logic [1:0] sb_MODO,
  output logic [3:0] sb_Q,
  output logic       sb_RCO,
  output logic       sb_LOAD
);

  localparam logic [1:0] MODE_UP    = 2'b00;
  localparam logic [1:0] MODE_DOWN1 = 2'b01;
  localparam logic [1:0] MODE_DOWN3 = 2'b10;

  // Bit 4 of the 5-bit result is the carry (up) or borrow (down).
  logic [4:0] sum;
  logic [3:0] q_next;
  logic       rco_next;
  logic       load_next;

  // Next-state selection; flags default to 0 so they pulse only on the edge that sets them.
  always_comb begin
    sum       = {1'b0, sb_Q};
    q_next    = sb_Q;
    rco_next  = 1'b0;
    load_next = 1'b0;
    if (ENABLE) begin
      case (sb_MODO)
        MODE_UP: begin
          sum      = {1'b0, sb_Q} + 5'd1;
          q_next   = sum[3:0];
          rco_next = sum[4];
        end
        MODE_DOWN1: begin
          sum      = {1'b0, sb_Q} - 5'd1;
          q_next   = sum[3:0];
          rco_next = sum[4];
        end
        MODE_DOWN3: begin
`ifdef SB_DOWN3_EN
          sum      = {1'b0, sb_Q} - 5'd3;
          q_next   = sum[3:0];
          rco_next = sum[4];
`else
          q_next   = sb_Q;
`endif
        end
        default: begin
          q_next    = sb_D;
          load_next = 1'b1;
        end
      endcase
    end
  end

  // Register outputs; reset takes priority over enable and any mode action.
  always_ff @(posedge clk) begin
    if (!RESET) begin
      sb_Q    <= 4'd0;
      sb_RCO  <= 1'b0;
      sb_LOAD <= 1'b0;
    end else begin
      sb_Q    <= q_next;
      sb_RCO  <= rco_next;
      sb_LOAD <= load_next;
    end
  end

endmodule

// File: tb/tb_scoreboard.sv
// tb/tb_scoreboard.sv - self-checking bench for scoreboard against an arithmetic model

module tb_scoreboard;

  logic       clk = 1'b0;
  logic       RESET = 1'b1;
  logic       ENABLE = 1'b0;
  logic [3:0] sb_D = 4'd0;
  logic [1:0] sb_MODO = 2'b00;
  logic [3:0] sb_Q;
  logic       sb_RCO;
  logic       sb_LOAD;

  int total = 0;
  int bad   = 0;

  // reference model state
  int mq = 0;
  int mrco = 0;
  int mload = 0;

  scoreboard dut (
    .clk     (clk),
    .RESET   (RESET),
    .ENABLE  (ENABLE),
    .sb_D    (sb_D),
    .sb_MODO (sb_MODO),
    .sb_Q    (sb_Q),
    .sb_RCO  (sb_RCO),
    .sb_LOAD (sb_LOAD)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Apply one edge of stimulus, advance the model, and compare all outputs.
  task automatic step(input logic r, input logic e, input logic [3:0] d, input logic [1:0] m);
    @(negedge clk);
    RESET = r; ENABLE = e; sb_D = d; sb_MODO = m;
    @(posedge clk);
    #1;
    if (!r) begin
      mq = 0; mrco = 0; mload = 0;
    end else if (!e) begin
      mrco = 0; mload = 0;
    end else begin
      mload = 0;
      case (m)
        2'd0: begin mrco = (mq == 15) ? 1 : 0; mq = (mq + 1) % 16; end
        2'd1: begin mrco = (mq == 0) ? 1 : 0;  mq = (mq + 15) % 16; end
        2'd2: begin
`ifdef SB_DOWN3_EN
          mrco = (mq < 3) ? 1 : 0; mq = (mq + 13) % 16;
`else
          mrco = 0;
`endif
        end
        default: begin mrco = 0; mq = int'(d); mload = 1; end
      endcase
    end
    check("q", {4'd0, sb_Q}, mq[7:0]);
    check("rco", {7'd0, sb_RCO}, mrco[7:0]);
    check("load", {7'd0, sb_LOAD}, mload[7:0]);
  endtask

  initial begin
    // reset beats a simultaneous load
    step(1'b0, 1'b1, 4'd9, 2'b11);
    check("reset_q_const", {4'd0, sb_Q}, 8'd0);
    check("reset_load_const", {7'd0, sb_LOAD}, 8'd0);

    // up-count wrap over 16 edges
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 1'b1, 4'd0, 2'b00);
      check("up_q_const", {4'd0, sb_Q}, 8'(i % 16));
      check("up_rco_const", {7'd0, sb_RCO}, (i == 16) ? 8'd1 : 8'd0);
    end

    // down-by-1 wrap
    step(1'b1, 1'b1, 4'd1, 2'b11);
    step(1'b1, 1'b1, 4'd0, 2'b01);
    check("dn1_q0", {4'd0, sb_Q}, 8'd0);
    step(1'b1, 1'b1, 4'd0, 2'b01);
    check("dn1_q15", {4'd0, sb_Q}, 8'd15);
    check("dn1_rco", {7'd0, sb_RCO}, 8'd1);

    // down-by-3 borrow (or hold when the mode is built out)
    step(1'b1, 1'b1, 4'd4, 2'b11);
    step(1'b1, 1'b1, 4'd0, 2'b10);
`ifdef SB_DOWN3_EN
    check("dn3_q1", {4'd0, sb_Q}, 8'd1);
`else
    check("dn3_hold", {4'd0, sb_Q}, 8'd4);
`endif
    step(1'b1, 1'b1, 4'd0, 2'b10);
`ifdef SB_DOWN3_EN
    check("dn3_q14", {4'd0, sb_Q}, 8'd14);
    check("dn3_rco", {7'd0, sb_RCO}, 8'd1);
`else
    check("dn3_hold2", {4'd0, sb_Q}, 8'd4);
`endif
    step(1'b1, 1'b1, 4'd0, 2'b10);

    // consecutive loads, then hold
    step(1'b1, 1'b1, 4'd10, 2'b11);
    check("load_q", {4'd0, sb_Q}, 8'd10);
    step(1'b1, 1'b1, 4'd3, 2'b11);
    check("load2_flag", {7'd0, sb_LOAD}, 8'd1);
    step(1'b1, 1'b1, 4'd10, 2'b11);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 4'd5, 2'b00);
      check("hold_q", {4'd0, sb_Q}, 8'd10);
    end

    // mid-count reset
    step(1'b0, 1'b1, 4'd0, 2'b00);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 4'd0, 2'b00);
    check("mid_q7", {4'd0, sb_Q}, 8'd7);
    step(1'b0, 1'b1, 4'd0, 2'b00);
    check("mid_rst", {4'd0, sb_Q}, 8'd0);
    step(1'b1, 1'b1, 4'd0, 2'b00);
    check("mid_rel", {4'd0, sb_Q}, 8'd1);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 19) != 0), ($urandom_range(0, 4) != 0),
           4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
